pf_ddr_dm_dly_ctrl: RTL
=======================

# pf_ddr_dm_dly_ctrl

Command-driven sequencer for the output delay line of one DDR4 data-mask lane IOD. It sits between the lane training logic and the IOD's `DELAY_LINE_MOVE/DIRECTION/LOAD` pins, all in the `FAB_CLK` domain. It converts load, increment-by-N and decrement-by-N requests into correctly spaced IOD control pulses. It tracks the resulting tap position and reports out-of-range aborts.

## Interface
- `TAP_W`, 8: tap counter width.
- `MAX_TAP`, 255: highest legal tap; an increment from here is refused.
- `INIT_TAP`, 1: tap value after reset or LOAD (matches IOD `TX_DELAY_VAL`).
- `MOVE_GAP`, 4: idle cycles after each MOVE pulse (≥1).
- `LOAD_CYCLES`, 2: LOAD pulse width (≥1).

Ports:
- `FAB_CLK` in 1: sole clock.
- `ARST_N` in 1: reset; asynchronous, active-low.
- `CMD_VALID` in 1: command request.
- `CMD_READY` out 1: block idle, can accept a command.
- `CMD_OP` in 2: 00 LOAD, 01 INC, 10 DEC, 11 NOP.
- `CMD_COUNT` in TAP_W: step count for INC/DEC.
- `DONE` out 1: one-cycle command-complete pulse.
- `ERR` out 1: status of the last command; valid with DONE, held until the next accept.
- `TAP_VAL` out TAP_W: tracked tap position.
- `DELAY_LINE_MOVE_0` out 1: to IOD.
- `DELAY_LINE_DIRECTION_0` out 1: to IOD; 1 = increment.
- `DELAY_LINE_LOAD_0` out 1: to IOD.
- `DELAY_LINE_OUT_OF_RANGE_0` in 1: from IOD; synchronous to `FAB_CLK`.

## Operation
- States: IDLE, LOAD, SETUP, MOVE, GAP, DONE.
- A command is accepted when `CMD_VALID && CMD_READY`. `CMD_READY` = 1 only in IDLE. The op and count are captured on acceptance.
- **LOAD**
  - `DELAY_LINE_LOAD_0` is high for LOAD_CYCLES cycles.
  - `TAP_VAL` ← INIT_TAP on the last LOAD cycle.
  - Then DONE, with ERR=0.
- **INC/DEC**
  - SETUP (1 cycle): `DELAY_LINE_DIRECTION_0` is driven and held for the whole command.
  - Then, per step: MOVE (MOVE high for 1 cycle; `TAP_VAL` ±1 in the same cycle), followed by GAP (MOVE_GAP cycles).
  - OOR is sampled on the last GAP cycle. If it is high: undo the step (`TAP_VAL` ∓1), skip the remaining steps, go to DONE with ERR=1.
  - Pre-check before each MOVE: INC at MAX_TAP or DEC at 0 issues no pulse; go to DONE with ERR=1.
- **COUNT=0 or NOP**: SETUP, then DONE; no pulses; ERR=0.
- **DONE**: 1 cycle, then IDLE.
- OOR is ignored outside GAP.
- `DELAY_LINE_DIRECTION_0` keeps its last value in IDLE.

## Timing
- Reset values:
  - `CMD_READY`=1; DONE, ERR, MOVE, LOAD, DIRECTION = 0.
  - `TAP_VAL`=INIT_TAP; state IDLE.
- Reset during a command drops MOVE/LOAD immediately. The IOD tap is then unknown, so training must issue LOAD first.
- Latency, with acceptance at edge 0:
  - LOAD: DONE in cycle LOAD_CYCLES+1.
  - INC/DEC of N steps with no error: DONE in cycle 2+N·(1+MOVE_GAP).
  - Error on step k: DONE in cycle 2+k·(1+MOVE_GAP).
- `CMD_READY` rises the cycle after DONE, so the next command can be accepted no earlier than that cycle.
- MOVE pulses are never closer than MOVE_GAP+1 cycles apart.
- MOVE and LOAD are never high together.
- All outputs are registered.

## Structure
- Shared package holds:
  - the `CMD_OP` encodings (LOAD/INC/DEC/NOP);
  - the state enum;
  - the default MOVE_GAP/LOAD_CYCLES constants used by all lane controllers.
- Single module; no sub-module. It needs a step counter (TAP_W bits) and a gap/load timer (width sized for max(MOVE_GAP, LOAD_CYCLES)), both inline.

## Test plan
- **Reset then LOAD** (defaults) → LOAD high in cycles 1–2, DONE in cycle 3, `TAP_VAL`=1, ERR=0.
- **INC COUNT=3**, no OOR → DIRECTION=1 from cycle 1, MOVE in cycles 2, 7, 12, DONE in cycle 17, `TAP_VAL`=4.
- **INC COUNT=5 with OOR forced high during the 2nd GAP** → exactly 2 MOVE pulses, DONE in cycle 12, ERR=1, `TAP_VAL` = start+1.
- **DEC COUNT=2 from `TAP_VAL`=1** → one MOVE, then refusal; DONE in cycle 7, ERR=1, `TAP_VAL`=0.
- **INC COUNT=0; then `CMD_VALID` held while busy** → DONE in cycle 2 with no pulses; the second command is not accepted until the cycle after DONE.
- **`ARST_N` low mid-GAP of an INC** → MOVE/LOAD drop immediately, `TAP_VAL`=1, `CMD_READY`=1, DONE never pulses.

Source files
------------

// File: rtl/pf_ddr_dm_dly_ctrl_pkg.sv
// pf_ddr_dm_dly_ctrl_pkg: shared command encodings, states and lane timing defaults
package pf_ddr_dm_dly_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_NOP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETUP,
        ST_MOVE,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int DEF_MOVE_GAP    = 4;
    localparam int DEF_LOAD_CYCLES = 2;

endpackage

// File: rtl/pf_ddr_dm_dly_ctrl.sv
// pf_ddr_dm_dly_ctrl: turns load/inc/dec commands into spaced IOD delay-line pulses and tracks the tap
module pf_ddr_dm_dly_ctrl
    import pf_ddr_dm_dly_ctrl_pkg::*;
#(
    parameter int TAP_W       = 8,
    parameter int MAX_TAP     = 255,
    parameter int INIT_TAP    = 1,
    parameter int MOVE_GAP    = DEF_MOVE_GAP,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [TAP_W-1:0] CMD_COUNT,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] TAP_VAL,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    localparam int TMAX  = (MOVE_GAP > LOAD_CYCLES) ? MOVE_GAP : LOAD_CYCLES;
    localparam int TMR_W = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(MOVE_GAP - 1);
    localparam logic [TMR_W-1:0] LOAD_LD = TMR_W'(LOAD_CYCLES - 1);
    localparam logic [TAP_W-1:0] INIT_V  = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] MAX_V   = TAP_W'(MAX_TAP);

    state_t             state;
    op_t                op_r;
    op_t                op_in;
    logic [TAP_W-1:0]   cnt;
    logic [TAP_W-1:0]   tap;
    logic [TMR_W-1:0]   tmr;
    logic               ready;
    logic               done;
    logic               err;
    logic               move;
    logic               load;
    logic               dir;
    logic               inc;
    logic               blocked;

    // decode the captured command and refuse steps that would leave the legal tap range
    always_comb begin
        op_in   = op_t'(CMD_OP);
        inc     = (op_r == OP_INC);
        blocked = inc ? (tap == MAX_V) : (tap == '0);
    end

    // command sequencer; every output is a register written here
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= ST_IDLE;
            op_r  <= OP_NOP;
            cnt   <= '0;
            tap   <= INIT_V;
            tmr   <= '0;
            ready <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
            move  <= 1'b0;
            load  <= 1'b0;
            dir   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (CMD_VALID) begin
                        ready <= 1'b0;
                        err   <= 1'b0;
                        op_r  <= op_in;
                        cnt   <= CMD_COUNT;
                        if (op_in == OP_LOAD) begin
                            state <= ST_LOAD;
                            load  <= 1'b1;
                            tmr   <= LOAD_LD;
                        end else begin
                            state <= ST_SETUP;
                            if (op_in != OP_NOP) dir <= (op_in == OP_INC);
                        end
                    end
                end
                ST_LOAD: begin
                    if (tmr == '0) begin
                        load  <= 1'b0;
                        tap   <= INIT_V;
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_SETUP, ST_GAP: begin
                    if (state == ST_GAP && tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (state == ST_GAP && DELAY_LINE_OUT_OF_RANGE_0) begin
                        // the IOD rejected the last step, so the tracked tap must follow it back
                        tap   <= inc ? tap - 1'b1 : tap + 1'b1;
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else if (op_r == OP_NOP || cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else if (blocked) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end else begin
                        state <= ST_MOVE;
                        move  <= 1'b1;
                        tap   <= inc ? tap + 1'b1 : tap - 1'b1;
                        cnt   <= cnt - 1'b1;
                    end
                end
                ST_MOVE: begin
                    move  <= 1'b0;
                    tmr   <= GAP_LD;
                    state <= ST_GAP;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign CMD_READY              = ready;
    assign DONE                   = done;
    assign ERR                    = err;
    assign TAP_VAL                = tap;
    assign DELAY_LINE_MOVE_0      = move;
    assign DELAY_LINE_DIRECTION_0 = dir;
    assign DELAY_LINE_LOAD_0      = load;

endmodule
